alu_rs_scheduler: RTL and testbench
===================================

# alu_rs_scheduler

Reservation station and issue scheduler for the integer ALU in the out-of-order core. It buffers up to `RS_SIZE` decoded ALU and branch micro-ops, wakes pending operands by snooping the common data bus (CDB), and dispatches at most one ready op per cycle into the combinational ALU through a registered issue stage. It sits between the dispatch/rename stage and the ALU; the ALU result returns on the CDB and is snooped here as well.

## Interface
Parameters:
- `RS_SIZE`, default 8: number of entries; power of two, at least 2.
- `TAG_W`, default 5: ROB tag width; matches the ALU `rd_in` width.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; synchronous, active-high.
- `rdy_in`  in  1  global ready; low freezes all state except reset and flush.
- `flush_in`  in  1  mispredict flush; drops all entries.
- `ins_valid`  in  1  insert request.
- `ins_op`  in  7  ALU opcode from `const.v`; 0 is illegal here.
- `ins_vi`, `ins_vj`  in  32  operand values, meaningful only when not pending.
- `ins_qi_busy`, `ins_qj_busy`  in  1  operand pending.
- `ins_qi`, `ins_qj`  in  TAG_W  producer tags for pending operands.
- `ins_imm`, `ins_pc`  in  32  immediate and instruction PC.
- `ins_rob`  in  TAG_W  destination ROB tag.
- `full_out`  out  1  all entries busy.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  TAG_W  CDB tag.
- `cdb_value`  in  32  CDB value.
- `alu_op_out`  out  7  issued opcode; 0 means no issue this cycle.
- `alu_vi_out`, `alu_vj_out`, `alu_imm_out`, `alu_pc_out`  out  32  issued operands.
- `alu_rob_out`  out  TAG_W  issued destination tag, driven to the ALU `rd_in`.

## Operation
- Each entry holds `busy`, `op`, `vi`, `vj`, `qi_busy`, `qj_busy`, `qi`, `qj`, `imm`, `pc`, and `rob`.
- **Insert.** Accepted when `ins_valid` and `!full_out`, and `rdy_in` is high with no flush. The op is written to the lowest-index free entry. An insert while `full_out` is high is ignored; preventing that is the sender's contract.
- **Insert-time forwarding.** If `cdb_valid` is high and `cdb_tag` equals a pending `ins_qi` or `ins_qj` in the same cycle, the entry stores `cdb_value` for that operand and clears its busy flag.
- **Wakeup.** Every cycle, every busy entry with `qX_busy` and `qX == cdb_tag` while `cdb_valid` is high captures `cdb_value` into `vX` and clears `qX_busy`. The two operands are handled independently.
- **Select.** The selected entry is the lowest-index entry with `busy && !qi_busy && !qj_busy`, evaluated on registered state only. An entry woken at an edge becomes selectable in the following cycle.
- **Dispatch.** At the edge:
  - The selected entry's fields load into the `alu_*_out` registers and the entry's `busy` is cleared.
  - If nothing is selectable, `alu_op_out` is set to 0 and the other `alu_*_out` registers hold their values.
  - The ALU treats `alu_op_out > 0` as valid, so each dispatch is a one-cycle pulse.
- **Full flag.** `full_out` is the AND of all `busy` bits and is combinational from registers. A slot freed by dispatch at edge E is visible in `full_out` after E.
- **Priority.** `rst_in` overrides `flush_in`, which overrides `rdy_in` gating, which overrides normal operation.
- **Flush.**
  - Clears every `busy` bit and sets `alu_op_out` to 0 at the edge.
  - A simultaneous insert is dropped and a simultaneous CDB broadcast is ignored.
- **Freeze.** While `rdy_in` is low: no insert, no wakeup, no dispatch, and all registers hold, including a nonzero `alu_op_out`. The CDB is also frozen during this time.

## Timing
- **Reset values.** All `busy` bits are 0. `full_out` is 0. `alu_op_out` and every other `alu_*_out` are 0.
- **Latency with ready operands.** An op inserted at edge E is selectable in cycle E+1. It appears on `alu_op_out` after edge E+1, one cycle minimum. There is no same-cycle bypass from insert to issue.
- **Latency through wakeup.** A CDB wakeup at edge W leads to issue after W+1.
- **Throughput.** One issue per cycle. Back-to-back ready entries issue on consecutive cycles in index order.
- **Simultaneous events on the same edge.** Insert, wakeup of other entries, and dispatch of a third entry all complete on the same edge. A freshly inserted entry is never dispatched on its insert edge.
- **Reset mid-operation.** Pending entries are discarded and the outputs return to their reset values at that edge.

## Structure
- Opcode defines and the 7-bit opcode width stay in the shared `const.v`. Add `RS_SIZE_DEF` and `ROB_TAG_W` there.
- Sub-module `rs_select` contains two parameterized lowest-index priority encoders:
  - free-slot encoder: outputs index plus an `any` flag;
  - ready-slot encoder: outputs index plus an `any` flag.
- Entry storage, wakeup, and the issue registers live in `alu_rs_scheduler`.

## Test plan
- **Reset then insert.** Insert ADD with vi=5, vj=7, no pending operands, rob=3 → after one edge, `alu_op_out`=ADD, vi=5, vj=7, `alu_rob_out`=3. On the next cycle `alu_op_out`=0.
- **CDB wakeup.** Insert SUB with qi pending on tag 9, vj=1. Broadcast CDB tag 9, value 0x10, three cycles later → issue after the following edge with vi=0x10, vj=1.
- **Insert-time forwarding.** Insert with qj=4 in the same cycle as a CDB broadcast of tag 4, value 0xFFFFFFFF → issue after one edge with vj=0xFFFFFFFF.
- **Full and select order.** Fill 8 entries with all operands pending; `full_out`=1 and an extra insert is ignored. Wake entries 6 and 2 together → entry 2 issues first, then entry 6. After entry 2 issues, `full_out`=0.
- **Flush.** With entries busy and an issue in flight, assert `flush_in` together with `ins_valid` → after the edge, every `busy`=0, `alu_op_out`=0, `full_out`=0, and the inserted op is never issued.
- **Freeze.** Hold `rdy_in` low for 4 cycles with one ready entry and a nonzero `alu_op_out` → outputs and entries are unchanged. The entry issues after the first edge with `rdy_in` high.

Source files
------------

// File: rtl/alu_rs_scheduler_pkg.sv
// alu_rs_scheduler_pkg: opcode encoding and default sizes shared by the ALU reservation station
package alu_rs_scheduler_pkg;
  localparam int OP_W = 7;
  localparam int RS_SIZE_DEF = 8;
  localparam int ROB_TAG_W = 5;
  typedef enum logic [OP_W-1:0] {
    OP_NONE = 7'd0,
    OP_ADD  = 7'd1,
    OP_SUB  = 7'd2,
    OP_AND  = 7'd3,
    OP_OR   = 7'd4,
    OP_XOR  = 7'd5,
    OP_SLL  = 7'd6,
    OP_BEQ  = 7'd7,
    OP_BNE  = 7'd8
  } alu_op_e;
endpackage

// File: rtl/alu_rs_scheduler_select.sv
// rs_select: lowest-index free-slot and ready-slot encoders (busy/ready in; free_idx/free_any, sel_idx/sel_any out)
module rs_select #(
  parameter int N = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  busy,
  input  logic [N-1:0]  ready,
  output logic [IW-1:0] free_idx,
  output logic          free_any,
  output logic [IW-1:0] sel_idx,
  output logic          sel_any
);
  always_comb begin
    free_idx = '0;
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      free_idx = busy[i] ? free_idx : i[IW-1:0];
      sel_idx = ready[i] ? i[IW-1:0] : sel_idx;
    end
  end
  assign free_any = ~&busy;
  assign sel_any = |ready;
endmodule

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: ALU reservation station (clk_in/rst_in/rdy_in/flush_in, ins_* insert, cdb_* wakeup, full_out, alu_*_out registered issue)
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             ins_valid,
  input  logic [OP_W-1:0]  ins_op,
  input  logic [31:0]      ins_vi,
  input  logic [31:0]      ins_vj,
  input  logic             ins_qi_busy,
  input  logic             ins_qj_busy,
  input  logic [TAG_W-1:0] ins_qi,
  input  logic [TAG_W-1:0] ins_qj,
  input  logic [31:0]      ins_imm,
  input  logic [31:0]      ins_pc,
  input  logic [TAG_W-1:0] ins_rob,
  output logic             full_out,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic [OP_W-1:0]  alu_op_out,
  output logic [31:0]      alu_vi_out,
  output logic [31:0]      alu_vj_out,
  output logic [31:0]      alu_imm_out,
  output logic [31:0]      alu_pc_out,
  output logic [TAG_W-1:0] alu_rob_out
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy, qi_busy, qj_busy, ready;
  logic [OP_W-1:0] op [RS_SIZE];
  logic [31:0] vi [RS_SIZE];
  logic [31:0] vj [RS_SIZE];
  logic [31:0] imm [RS_SIZE];
  logic [31:0] pc [RS_SIZE];
  logic [TAG_W-1:0] qi [RS_SIZE];
  logic [TAG_W-1:0] qj [RS_SIZE];
  logic [TAG_W-1:0] rob [RS_SIZE];
  logic [IW-1:0] free_idx, sel_idx;
  logic free_any, sel_any, ins_ok, fwd_i, fwd_j;
  assign ready = busy & ~qi_busy & ~qj_busy;
  assign full_out = &busy;
  assign ins_ok = ins_valid && free_any;
  // operands pending on the tag being broadcast right now are captured at insert
  assign fwd_i = ins_qi_busy && cdb_valid && ins_qi == cdb_tag;
  assign fwd_j = ins_qj_busy && cdb_valid && ins_qj == cdb_tag;
  rs_select #(.N(RS_SIZE)) u_sel (
    .busy(busy),
    .ready(ready),
    .free_idx(free_idx),
    .free_any(free_any),
    .sel_idx(sel_idx),
    .sel_any(sel_any)
  );
  // the dispatched entry is already ready and the insert slot is free, so the
  // wakeup, dispatch and insert writes below never target the same field
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
      alu_op_out <= OP_NONE;
      alu_vi_out <= '0;
      alu_vj_out <= '0;
      alu_imm_out <= '0;
      alu_pc_out <= '0;
      alu_rob_out <= '0;
    end else if (flush_in) begin
      busy <= '0;
      alu_op_out <= OP_NONE;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (cdb_valid && busy[i] && qi_busy[i] && qi[i] == cdb_tag) begin
          vi[i] <= cdb_value;
          qi_busy[i] <= 1'b0;
        end
        if (cdb_valid && busy[i] && qj_busy[i] && qj[i] == cdb_tag) begin
          vj[i] <= cdb_value;
          qj_busy[i] <= 1'b0;
        end
      end
      if (sel_any) begin
        alu_op_out <= op[sel_idx];
        alu_vi_out <= vi[sel_idx];
        alu_vj_out <= vj[sel_idx];
        alu_imm_out <= imm[sel_idx];
        alu_pc_out <= pc[sel_idx];
        alu_rob_out <= rob[sel_idx];
        busy[sel_idx] <= 1'b0;
      end else begin
        alu_op_out <= OP_NONE;
      end
      if (ins_ok) begin
        busy[free_idx] <= 1'b1;
        op[free_idx] <= ins_op;
        vi[free_idx] <= fwd_i ? cdb_value : ins_vi;
        vj[free_idx] <= fwd_j ? cdb_value : ins_vj;
        qi_busy[free_idx] <= ins_qi_busy && !fwd_i;
        qj_busy[free_idx] <= ins_qj_busy && !fwd_j;
        qi[free_idx] <= ins_qi;
        qj[free_idx] <= ins_qj;
        imm[free_idx] <= ins_imm;
        pc[free_idx] <= ins_pc;
        rob[free_idx] <= ins_rob;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: directed vector and sequence checks for alu_rs_scheduler
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rst_in, rdy_in, flush_in, ins_valid, ins_qi_busy, ins_qj_busy, full_out, cdb_valid;
  logic [6:0] ins_op, alu_op_out;
  logic [31:0] ins_vi, ins_vj, ins_imm, ins_pc, cdb_value;
  logic [31:0] alu_vi_out, alu_vj_out, alu_imm_out, alu_pc_out;
  logic [4:0] ins_qi, ins_qj, ins_rob, cdb_tag, alu_rob_out;
  int tests = 0;
  int fails = 0;
  alu_rs_scheduler dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .ins_valid(ins_valid), .ins_op(ins_op), .ins_vi(ins_vi), .ins_vj(ins_vj),
    .ins_qi_busy(ins_qi_busy), .ins_qj_busy(ins_qj_busy), .ins_qi(ins_qi), .ins_qj(ins_qj),
    .ins_imm(ins_imm), .ins_pc(ins_pc), .ins_rob(ins_rob), .full_out(full_out),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_op_out(alu_op_out), .alu_vi_out(alu_vi_out), .alu_vj_out(alu_vj_out),
    .alu_imm_out(alu_imm_out), .alu_pc_out(alu_pc_out), .alu_rob_out(alu_rob_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0] op;
    logic [31:0] vi, vj;
    logic qib, qjb;
    logic [4:0] qi, qj;
    logic cv;
    logic [4:0] ct;
    logic [31:0] cval, imm, pc;
    logic [4:0] rob;
    logic issue;
    logic [31:0] evi, evj;
  } vec_t;
  vec_t v [7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    flush_in = 1'b0;
    ins_valid = 1'b0;
    cdb_valid = 1'b0;
  endtask
  task automatic ins(input logic [6:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic qib, input logic qjb, input logic [4:0] qa, input logic [4:0] qb,
                     input logic [4:0] r);
    ins_valid = 1'b1;
    ins_op = o;
    ins_vi = a;
    ins_vj = b;
    ins_qi_busy = qib;
    ins_qj_busy = qjb;
    ins_qi = qa;
    ins_qj = qb;
    ins_imm = 32'h100 + 32'(r);
    ins_pc = 32'h1000 + 32'(r) * 4;
    ins_rob = r;
  endtask
  task automatic cdb(input logic [4:0] t, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag = t;
    cdb_value = val;
  endtask
  task automatic do_flush;
    idle();
    flush_in = 1'b1;
    tick();
    idle();
  endtask
  initial begin
    idle();
    cdb_tag = '0;
    cdb_value = '0;
    ins(OP_NONE, 0, 0, 0, 0, 0, 0, 0);
    ins_valid = 1'b0;
    v[0] = '{OP_ADD, 5, 7, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h100, 3, 1, 5, 7};
    v[1] = '{OP_AND, 32'h12345678, 0, 0, 1, 0, 4, 1, 4, 32'hFFFFFFFF, 32'h20, 32'h104, 4, 1, 32'h12345678, 32'hFFFFFFFF};
    v[2] = '{OP_OR, 0, 3, 1, 0, 9, 0, 1, 10, 32'h55, 32'h30, 32'h108, 5, 0, 0, 0};
    v[3] = '{OP_XOR, 1, 2, 1, 1, 6, 6, 1, 6, 32'hA5, 32'h40, 32'h10C, 6, 1, 32'hA5, 32'hA5};
    v[4] = '{OP_BEQ, 0, 0, 1, 1, 3, 8, 1, 3, 32'h55, 32'h50, 32'h110, 7, 0, 0, 0};
    v[5] = '{OP_SLL, 0, 4, 1, 0, 11, 0, 0, 11, 32'h66, 32'h60, 32'h114, 8, 0, 0, 0};
    v[6] = '{OP_BNE, 1, 2, 0, 0, 2, 2, 1, 2, 32'h99, 32'hFFFFFFFF, 32'hDEADBEEC, 31, 1, 1, 2};
    rst_in = 1'b1;
    tick();
    tick();
    idle();
    chk("rst_op", 32'(alu_op_out), 0);
    chk("rst_vi", alu_vi_out, 0);
    chk("rst_vj", alu_vj_out, 0);
    chk("rst_imm", alu_imm_out, 0);
    chk("rst_pc", alu_pc_out, 0);
    chk("rst_rob", 32'(alu_rob_out), 0);
    chk("rst_full", 32'(full_out), 0);
    for (int k = 0; k < 7; k++) begin
      ins(v[k].op, v[k].vi, v[k].vj, v[k].qib, v[k].qjb, v[k].qi, v[k].qj, v[k].rob);
      ins_imm = v[k].imm;
      ins_pc = v[k].pc;
      cdb_valid = v[k].cv;
      cdb_tag = v[k].ct;
      cdb_value = v[k].cval;
      tick();
      idle();
      chk($sformatf("v%0d_no_bypass", k), 32'(alu_op_out), 0);
      tick();
      chk($sformatf("v%0d_op", k), 32'(alu_op_out), v[k].issue ? 32'(v[k].op) : 0);
      if (v[k].issue) begin
        chk($sformatf("v%0d_vi", k), alu_vi_out, v[k].evi);
        chk($sformatf("v%0d_vj", k), alu_vj_out, v[k].evj);
        chk($sformatf("v%0d_imm", k), alu_imm_out, v[k].imm);
        chk($sformatf("v%0d_pc", k), alu_pc_out, v[k].pc);
        chk($sformatf("v%0d_rob", k), 32'(alu_rob_out), 32'(v[k].rob));
      end
      tick();
      chk($sformatf("v%0d_pulse", k), 32'(alu_op_out), 0);
      do_flush();
    end
    ins(OP_SUB, 0, 1, 1, 0, 9, 0, 4);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      chk("wake_wait", 32'(alu_op_out), 0);
      tick();
    end
    cdb(9, 32'h10);
    tick();
    idle();
    chk("wake_edge", 32'(alu_op_out), 0);
    tick();
    chk("wake_op", 32'(alu_op_out), OP_SUB);
    chk("wake_vi", alu_vi_out, 32'h10);
    chk("wake_vj", alu_vj_out, 1);
    chk("wake_rob", 32'(alu_rob_out), 4);
    do_flush();
    for (int k = 0; k < 8; k++) begin
      ins(OP_ADD, 100 + k, 200 + k, 1, 0, (k == 2 || k == 6) ? 5'd7 : 5'(10 + k), 0, 5'(k));
      tick();
    end
    idle();
    chk("full_set", 32'(full_out), 1);
    ins(OP_ADD, 1, 1, 0, 0, 0, 0, 31);
    tick();
    idle();
    chk("full_hold", 32'(full_out), 1);
    chk("full_no_issue", 32'(alu_op_out), 0);
    cdb(7, 32'h77);
    tick();
    idle();
    chk("sel_edge", 32'(alu_op_out), 0);
    tick();
    chk("sel_first_op", 32'(alu_op_out), OP_ADD);
    chk("sel_first_rob", 32'(alu_rob_out), 2);
    chk("sel_first_vi", alu_vi_out, 32'h77);
    chk("sel_first_vj", alu_vj_out, 202);
    chk("full_clear", 32'(full_out), 0);
    tick();
    chk("sel_second_op", 32'(alu_op_out), OP_ADD);
    chk("sel_second_rob", 32'(alu_rob_out), 6);
    chk("sel_second_vj", alu_vj_out, 206);
    tick();
    chk("sel_extra_dropped", 32'(alu_op_out), 0);
    do_flush();
    ins(OP_ADD, 1, 1, 0, 0, 0, 0, 1);
    tick();
    ins(OP_SUB, 2, 2, 0, 0, 0, 0, 2);
    tick();
    idle();
    chk("fl_inflight", 32'(alu_op_out), OP_ADD);
    ins(OP_XOR, 3, 3, 0, 0, 0, 0, 5);
    flush_in = 1'b1;
    tick();
    idle();
    chk("fl_op", 32'(alu_op_out), 0);
    chk("fl_full", 32'(full_out), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl_drained", 32'(alu_op_out), 0);
    end
    ins(OP_ADD, 1, 1, 0, 0, 0, 0, 1);
    tick();
    ins(OP_SUB, 9, 8, 0, 0, 0, 0, 2);
    tick();
    idle();
    rdy_in = 1'b0;
    ins(OP_XOR, 3, 3, 0, 0, 0, 0, 3);
    cdb(3, 32'h33);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("frz_op", 32'(alu_op_out), OP_ADD);
      chk("frz_rob", 32'(alu_rob_out), 1);
    end
    idle();
    tick();
    chk("frz_resume_op", 32'(alu_op_out), OP_SUB);
    chk("frz_resume_rob", 32'(alu_rob_out), 2);
    chk("frz_resume_vi", alu_vi_out, 9);
    tick();
    chk("frz_no_insert", 32'(alu_op_out), 0);
    ins(OP_ADD, 1, 1, 0, 0, 0, 0, 1);
    tick();
    ins(OP_SUB, 2, 2, 1, 0, 12, 0, 2);
    tick();
    idle();
    rst_in = 1'b1;
    tick();
    idle();
    chk("mrst_op", 32'(alu_op_out), 0);
    chk("mrst_rob", 32'(alu_rob_out), 0);
    chk("mrst_vi", alu_vi_out, 0);
    chk("mrst_full", 32'(full_out), 0);
    cdb(12, 32'h1);
    tick();
    idle();
    tick();
    chk("mrst_discard", 32'(alu_op_out), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
